// File: rtl/ndata_stim_gen_if.sv
// Control and output bundle of the NDATA stimulus generator.
// The master side drives the controls; the slave side (the generator) drives ndata.
interface ndata_stim_gen_if #(
    parameter int unsigned NBINS  = 37,
    parameter int unsigned RATE_W = 24,
    parameter int unsigned IDX_W  = $clog2(NBINS)
);
    logic              pause;
    logic              restart;
    logic              gate;
    logic [1:0]        mode;
    logic [RATE_W-1:0] rate;
    logic [IDX_W-1:0]  fixed_bin;
    logic [NBINS-1:0]  ndata;
    logic [IDX_W-1:0]  bin_idx;
    logic              step_pulse;

    modport master (
        output pause, restart, gate, mode, rate, fixed_bin,
        input  ndata, bin_idx, step_pulse
    );

    modport slave (
        input  pause, restart, gate, mode, rate, fixed_bin,
        output ndata, bin_idx, step_pulse
    );
endinterface

// File: rtl/ndata_stim_gen.sv
// Rate-controlled one-hot note-bin generator (walk / bounce / fixed / pseudo-random)
// standing in for the FFT front end of the scorer.
module ndata_stim_gen #(
    parameter int unsigned NBINS  = 37,
    parameter int unsigned RATE_W = 24,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input logic             clk,
    input logic             reset_n,
    ndata_stim_gen_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NBINS);

    localparam logic [15:0]      SeedEff = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [IDX_W-1:0] LastBin = IDX_W'(NBINS - 1);
    localparam logic [IDX_W:0]   NbinsW  = (IDX_W + 1)'(NBINS);
    localparam logic [NBINS-1:0] OneHot0 = NBINS'(1);

    typedef enum logic [1:0] {ModeWalk, ModeBounce, ModeFixed, ModeRandom} mode_e;

    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  bin_q, bin_d;
    logic              dir_q, dir_d;      // 0 = up, 1 = down
    logic [15:0]       lfsr_q, lfsr_d;
    logic [NBINS-1:0]  onehot_q, onehot_d;
    logic              step_q, step_d;

    logic [RATE_W-1:0] rate_m1;
    logic              step_due;
    logic [15:0]       lfsr_adv;
    logic [IDX_W:0]    rnd_ext;
    logic [IDX_W:0]    rnd_fold;
    logic [IDX_W-1:0]  bin_nxt;
    logic              dir_nxt;
    logic [15:0]       lfsr_nxt;
    mode_e             mode;

    assign mode = mode_e'(bus.mode);

    // rate-1 only formed for rate >= 2; rate 0/1 step unconditionally.
    always_comb begin
        rate_m1  = (bus.rate >= RATE_W'(2)) ? (bus.rate - RATE_W'(1)) : '0;
        step_due = (bus.rate <= RATE_W'(1)) || (cnt_q >= rate_m1);
    end

    // Galois right-shift LFSR, taps 16'hB400; one subtraction folds into [0, NBINS).
    always_comb begin
        lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        rnd_ext  = {1'b0, lfsr_adv[IDX_W-1:0]};
        rnd_fold = (rnd_ext >= NbinsW) ? (rnd_ext - NbinsW) : rnd_ext;
    end

    always_comb begin
        bin_nxt  = bin_q;
        dir_nxt  = dir_q;
        lfsr_nxt = lfsr_q;
        unique case (mode)
            ModeWalk: bin_nxt = (bin_q == LastBin) ? '0 : bin_q + 1'b1;
            ModeBounce: begin
                if (!dir_q) begin
                    if (bin_q == LastBin) begin
                        dir_nxt = 1'b1;
                        bin_nxt = LastBin - 1'b1;
                    end else begin
                        bin_nxt = bin_q + 1'b1;
                    end
                end else begin
                    if (bin_q == '0) begin
                        dir_nxt = 1'b0;
                        bin_nxt = IDX_W'(1);
                    end else begin
                        bin_nxt = bin_q - 1'b1;
                    end
                end
            end
            ModeFixed: bin_nxt = (bus.fixed_bin > LastBin) ? LastBin : bus.fixed_bin;
            ModeRandom: begin
                lfsr_nxt = lfsr_adv;
                bin_nxt  = rnd_fold[IDX_W-1:0];
            end
            default: bin_nxt = bin_q;
        endcase
    end

    // Priority: restart > pause > step.
    always_comb begin
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        dir_d    = dir_q;
        lfsr_d   = lfsr_q;
        onehot_d = onehot_q;
        step_d   = 1'b0;
        if (bus.restart) begin
            cnt_d    = '0;
            bin_d    = '0;
            dir_d    = 1'b0;
            lfsr_d   = SeedEff;
            onehot_d = OneHot0;
        end else if (!bus.pause) begin
            if (step_due) begin
                cnt_d    = '0;
                bin_d    = bin_nxt;
                dir_d    = dir_nxt;
                lfsr_d   = lfsr_nxt;
                onehot_d = OneHot0 << bin_nxt;
                step_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            bin_q    <= '0;
            dir_q    <= 1'b0;
            lfsr_q   <= SeedEff;
            onehot_q <= OneHot0;
            step_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            dir_q    <= dir_d;
            lfsr_q   <= lfsr_d;
            onehot_q <= onehot_d;
            step_q   <= step_d;
        end
    end

    assign bus.ndata      = onehot_q & {NBINS{bus.gate}};
    assign bus.bin_idx    = bin_q;
    assign bus.step_pulse = step_q;
endmodule

// File: tb/tb_ndata_stim_gen.sv
// Directed bench for ndata_stim_gen with NBINS=37, RATE_W=24, SEED=16'hACE1.
module tb_ndata_stim_gen;
    localparam int unsigned NBINS  = 37;
    localparam int unsigned RATE_W = 24;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ndata_stim_gen_if #(.NBINS(NBINS), .RATE_W(RATE_W)) bus ();

    ndata_stim_gen #(.NBINS(NBINS), .RATE_W(RATE_W), .SEED(16'hACE1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects no pulse for period-1 cycles, then a pulse carrying exp_bin.
    task automatic run_to_step(input int period, input int exp_bin, input string tag);
        for (int k = 1; k < period; k++) begin
            tick();
            check_eq({tag, "_nopulse"}, 64'(bus.step_pulse), 64'd0);
        end
        tick();
        check_eq({tag, "_pulse"}, 64'(bus.step_pulse), 64'd1);
        check_eq({tag, "_bin"}, 64'(bus.bin_idx), 64'(exp_bin));
        check_eq({tag, "_ndata"}, 64'(bus.ndata), 64'd1 << exp_bin);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        check_eq("restart_bin", 64'(bus.bin_idx), 64'd0);
        check_eq("restart_pulse", 64'(bus.step_pulse), 64'd0);
    endtask

    // Hand-computed folds of the LFSR sequence from 16'hACE1.
    int rnd_tbl[10] = '{11, 19, 28, 14, 2, 19, 9, 4, 34, 12};

    initial begin
        int exp_bin;
        int p;
        bus.pause     = 1'b0;
        bus.restart   = 1'b0;
        bus.gate      = 1'b1;
        bus.mode      = 2'd0;
        bus.rate      = RATE_W'(4);
        bus.fixed_bin = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_ndata", 64'(bus.ndata), 64'd1);
        check_eq("rst_bin", 64'(bus.bin_idx), 64'd0);
        check_eq("rst_pulse", 64'(bus.step_pulse), 64'd0);
        reset_n = 1'b1;

        // WALK rate=4: one full lap in 148 cycles
        for (int i = 1; i <= 148; i++) begin
            tick();
            exp_bin = (i / 4) % 37;
            check_eq("walk_pulse", 64'(bus.step_pulse), (i % 4 == 0) ? 64'd1 : 64'd0);
            check_eq("walk_bin", 64'(bus.bin_idx), 64'(exp_bin));
            check_eq("walk_ndata", 64'(bus.ndata), 64'd1 << exp_bin);
        end

        // BOUNCE rate=1: 0..36,35..0,1
        do_restart();
        bus.mode = 2'd1;
        bus.rate = RATE_W'(1);
        for (int k = 1; k <= 73; k++) begin
            tick();
            p = k % 72;
            exp_bin = (p <= 36) ? p : 72 - p;
            check_eq("bounce_pulse", 64'(bus.step_pulse), 64'd1);
            check_eq("bounce_bin", 64'(bus.bin_idx), 64'(exp_bin));
        end

        // FIXED rate=3: clamp, sample only on step, then bounce from the top edge
        do_restart();
        bus.mode      = 2'd2;
        bus.rate      = RATE_W'(3);
        bus.fixed_bin = 6'd50;
        run_to_step(3, 36, "fixed_clamp");
        bus.fixed_bin = 6'd5;
        tick();
        check_eq("fixed_hold", 64'(bus.bin_idx), 64'd36);
        tick();
        check_eq("fixed_hold2", 64'(bus.bin_idx), 64'd36);
        tick();
        check_eq("fixed_new_pulse", 64'(bus.step_pulse), 64'd1);
        check_eq("fixed_new_bin", 64'(bus.bin_idx), 64'd5);
        bus.fixed_bin = 6'd63;
        run_to_step(3, 36, "fixed_max");
        bus.mode = 2'd1;
        run_to_step(3, 35, "bounce_entry");

        // RANDOM rate=2, with a WALK excursion that must freeze the LFSR
        do_restart();
        bus.mode = 2'd3;
        bus.rate = RATE_W'(2);
        for (int k = 0; k < 6; k++) begin
            run_to_step(2, rnd_tbl[k], "rand_a");
            check_eq("rand_range", 64'(bus.bin_idx < 6'd37), 64'd1);
        end
        bus.mode = 2'd0;
        run_to_step(2, 20, "rand_walk1");
        run_to_step(2, 21, "rand_walk2");
        bus.mode = 2'd3;
        for (int k = 6; k < 10; k++) begin
            run_to_step(2, rnd_tbl[k], "rand_b");
        end

        // Pause at cnt=2 of rate=5 for 10 cycles; partial count resumes
        do_restart();
        bus.mode = 2'd0;
        bus.rate = RATE_W'(5);
        tick();
        tick();
        bus.pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("pause_pulse", 64'(bus.step_pulse), 64'd0);
            check_eq("pause_bin", 64'(bus.bin_idx), 64'd0);
            check_eq("pause_ndata", 64'(bus.ndata), 64'd1);
        end
        bus.pause = 1'b0;
        run_to_step(3, 1, "resume");

        // restart + pause together: restart wins and reloads the seed
        bus.mode = 2'd3;
        bus.rate = RATE_W'(1);
        tick();
        tick();
        tick();
        check_eq("pre_restart_bin", 64'(bus.bin_idx), 64'd28);
        bus.restart = 1'b1;
        bus.pause   = 1'b1;
        tick();
        check_eq("rp_bin", 64'(bus.bin_idx), 64'd0);
        check_eq("rp_ndata", 64'(bus.ndata), 64'd1);
        check_eq("rp_pulse", 64'(bus.step_pulse), 64'd0);
        bus.restart = 1'b0;
        bus.pause   = 1'b0;
        tick();
        check_eq("seed_reload_bin", 64'(bus.bin_idx), 64'd11);

        // Async reset mid-cycle
        bus.mode = 2'd0;
        tick();
        tick();
        check_eq("pre_rst_bin", 64'(bus.bin_idx), 64'd13);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_bin", 64'(bus.bin_idx), 64'd0);
        check_eq("async_ndata", 64'(bus.ndata), 64'd1);
        check_eq("async_pulse", 64'(bus.step_pulse), 64'd0);
        tick();
        reset_n = 1'b1;

        // Gating: ndata forced to zero while bin_idx advances
        bus.gate = 1'b0;
        #1;
        check_eq("gate_imm", 64'(bus.ndata), 64'd0);
        tick();
        check_eq("gate_ndata1", 64'(bus.ndata), 64'd0);
        check_eq("gate_bin1", 64'(bus.bin_idx), 64'd1);
        check_eq("gate_pulse1", 64'(bus.step_pulse), 64'd1);
        tick();
        check_eq("gate_ndata2", 64'(bus.ndata), 64'd0);
        check_eq("gate_bin2", 64'(bus.bin_idx), 64'd2);
        bus.gate = 1'b1;
        #1;
        check_eq("ungate_ndata", 64'(bus.ndata), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
